// File: rtl/waveform_sequencer.sv
// Segment sequencer feeding the signal generator's waveform select and phase increment.
// Optional per-cycle increment sweep is built when WAVESEQ_SWEEP_EN is defined.
module waveform_sequencer #(
    parameter  int DEPTH = 8,
    parameter  int DUR_W = 24,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [2:0]       wr_wave,
    input  logic [31:0]      wr_adder,
    input  logic [31:0]      wr_step,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW-1:0]    last_seg,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [2:0]       signal_number,
    output logic [31:0]      adder,
    output logic [AW-1:0]    seg_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       tbl_wave_q  [DEPTH];
    logic [31:0]      tbl_adder_q [DEPTH];
    logic [DUR_W-1:0] tbl_dur_q   [DEPTH];

    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    seg_q, seg_d;
    logic [AW-1:0]    last_q, last_d;
    logic             loop_q, loop_d;
    logic [2:0]       sig_q, sig_d;
    logic [31:0]      inc_q, inc_d;
    logic [31:0]      adder_q, adder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ld;
    logic [AW-1:0]    ld_idx;
    logic             cnt_last;
    logic             last_hit;
    logic [DUR_W-1:0] ld_dur;

`ifdef WAVESEQ_SWEEP_EN
    logic [31:0] tbl_step_q [DEPTH];
    logic [31:0] step_q, step_d;
`else
    logic        unused_step;
    assign unused_step = ^wr_step;
`endif

    // Table: asynchronous read, so a same-cycle write is seen only after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_wave_q[i]  <= '0;
                tbl_adder_q[i] <= '0;
                tbl_dur_q[i]   <= '0;
`ifdef WAVESEQ_SWEEP_EN
                tbl_step_q[i]  <= '0;
`endif
            end
        end else if (wr_en) begin
            tbl_wave_q[wr_addr]  <= wr_wave;
            tbl_adder_q[wr_addr] <= wr_adder;
            tbl_dur_q[wr_addr]   <= wr_dur;
`ifdef WAVESEQ_SWEEP_EN
            tbl_step_q[wr_addr]  <= wr_step;
`endif
        end
    end

    assign cnt_last = (cnt_q == DUR_W'(1));
    assign last_hit = (seg_q == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RUN and PAUSE share one step: leaving PAUSE performs the edge that pausing deferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = pause ? S_PAUSE : S_RUN;
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (cnt_last && last_hit && !loop_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        last_d  = last_q;
        loop_d  = loop_q;
        sig_d   = sig_q;
        inc_d   = inc_q;
        adder_d = adder_q;
        ld      = 1'b0;
        ld_idx  = '0;
`ifdef WAVESEQ_SWEEP_EN
        step_d  = step_q;
`endif
        case (state_q)
            S_IDLE: begin
                adder_d = '0;
                if (start && !stop) begin
                    ld     = 1'b1;
                    last_d = last_seg;
                    loop_d = loop_en;
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop || pause) begin
                    adder_d = '0;
                end else if (cnt_last) begin
                    if (!last_hit) begin
                        ld     = 1'b1;
                        ld_idx = seg_q + 1'b1;
                    end else if (loop_q) begin
                        ld     = 1'b1;
                    end else begin
                        adder_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
`ifdef WAVESEQ_SWEEP_EN
                    inc_d = inc_q + step_q;
`endif
                    adder_d = inc_d;
                end
            end
            default: begin
                adder_d = '0;
            end
        endcase

        ld_dur = tbl_dur_q[ld_idx];
        if (ld) begin
            seg_d   = ld_idx;
            sig_d   = tbl_wave_q[ld_idx];
            inc_d   = tbl_adder_q[ld_idx];
            cnt_d   = (ld_dur == '0) ? DUR_W'(1) : ld_dur;
            adder_d = pause ? '0 : tbl_adder_q[ld_idx];
`ifdef WAVESEQ_SWEEP_EN
            step_d  = tbl_step_q[ld_idx];
`endif
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            seg_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            sig_q   <= '0;
            inc_q   <= '0;
            adder_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WAVESEQ_SWEEP_EN
            step_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            sig_q   <= sig_d;
            inc_q   <= inc_d;
            adder_q <= adder_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WAVESEQ_SWEEP_EN
            step_q  <= step_d;
`endif
        end
    end

    assign signal_number = sig_q;
    assign adder         = adder_q;
    assign seg_idx       = seg_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/waveform_sequencer.md
# waveform_sequencer

Programmable segment sequencer that drives the waveform-select and phase-increment inputs of the signal generator. It holds a small table of segments; each segment gives a waveform code, a phase increment and a duration. Once started, it plays the segments back in order, either once or looping, so that multi-tone, burst and chirp patterns need no CPU involvement. It sits between the host register interface and the signal generator; its `signal_number` and `adder` outputs connect directly to the generator inputs of the same names.

## Interface
Parameters:
- `DEPTH`, default 8: number of segment entries; must be a power of 2, ≥ 2.
- `DUR_W`, default 24: width of the per-segment duration field.

Ports (`AW` = clog2(DEPTH)):
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  entry index to write.
- `wr_wave`  in  3  waveform code for the entry (0 saw, 1 ramp, 2 square, 3 triangle, 4 sine, 5 noise).
- `wr_adder`  in  32  phase increment for the entry.
- `wr_step`  in  32  signed per-cycle increment delta (sweep only).
- `wr_dur`  in  DUR_W  segment length in cycles; a value of 0 is treated as 1.
- `last_seg`  in  AW  index of the final segment; sampled on `start`.
- `loop_en`  in  1  wrap to entry 0 after `last_seg`; sampled on `start`.
- `start`  in  1  begin playback (single-cycle pulse).
- `stop`  in  1  abort playback.
- `pause`  in  1  level; freezes playback while high.
- `signal_number`  out  3  to the generator's `signalNumber`.
- `adder`  out  32  to the generator's `adder`.
- `seg_idx`  out  AW  index of the active segment.
- `busy`  out  1  high in RUN and PAUSE.
- `done`  out  1  one-cycle pulse when a non-looping sequence completes.

## Operation
- The table is a flop array with asynchronous read. A write updates it on the clock edge.
  - When a write and a read of the same entry occur in the same cycle, the read returns the old contents.
  - Writes are accepted in every state.
- FSM states are IDLE, RUN, PAUSE and DONE.
- **IDLE**
  - `adder`=0, which freezes the generator's phase. `signal_number` holds its last value.
  - On `start` (with `stop` low): load entry 0 into the outputs, set the counter to max(dur,1), set `seg_idx`=0, latch `last_seg`/`loop_en`, and go to RUN.
- **RUN**
  - The counter decrements every cycle.
  - When counter==1 and `seg_idx`<`last_seg`: load entry `seg_idx`+1 at that edge, with no gap cycle.
  - When counter==1 and `seg_idx`==`last_seg`:
    - if `loop_en`, load entry 0;
    - otherwise go to DONE.
  - If `pause` is high, go to PAUSE. The counter does not decrement on that edge.
- **PAUSE**
  - `adder`=0; the counter and `seg_idx` hold.
  - When `pause` goes low, restore the segment increment and return to RUN.
- **DONE**
  - `done`=1 and `adder`=0 for one cycle, then go to IDLE.
- `stop`, sampled in any state other than IDLE, forces IDLE on the next edge with `adder`=0 and no `done` pulse.
- Priority is `stop` > `pause` > `start`. `start` is ignored outside IDLE.
- If `last_seg` ≥ `DEPTH`, it cannot be encoded, so no range check is needed.

## Timing
- Reset values: `signal_number`=0, `adder`=0, `seg_idx`=0, `busy`=0, `done`=0. State is IDLE, the counter is 0, and table contents are 0.
- Latency: `start` at edge N puts segment 0 on the outputs after edge N, and `busy`=1 from that same edge.
- Each segment drives its outputs for exactly max(dur,1) cycles, excluding paused cycles.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-sequence returns every output to its reset value immediately, i.e. asynchronously.

## Configuration
- `WAVESEQ_SWEEP_EN`
  - **Defined:** the table also stores `wr_step`. While in RUN, `adder` <= `adder` + `step` on every cycle after segment load, wrapping modulo 2^32. Each segment load restores the entry's base `wr_adder`. PAUSE freezes the swept value, and resuming continues from it.
  - **Undefined:** `wr_step` is ignored and no step storage is built. `adder` is constant within a segment.

## Test plan
- Reset mid-RUN with `adder`=0x01000000 → all outputs read 0 immediately, with no clock edge needed.
- Entries {0:(wave 4, 0x00100000, dur 3), 1:(wave 2, 0x00200000, dur 2)}, `last_seg`=1, `loop_en`=0, `start` → the output sequence is wave 4 for 3 cycles, wave 2 for 2 cycles, then a `done` pulse on the next cycle with `adder`=0, then IDLE.
- Same table with `loop_en`=1 → the sequence repeats every 5 cycles for 20 cycles with no `done`. `stop` during this → IDLE on the next edge with `adder`=0 and no `done`.
- `dur`=0 on entry 0 with `last_seg`=0 → exactly 1 RUN cycle, then `done`.
- `pause` held for 4 cycles mid-segment (dur 6) → `adder`=0 for those 4 cycles, and the segment still drives its increment for 6 active cycles in total. `start` and `stop` in the same cycle → no change from IDLE.
- With `WAVESEQ_SWEEP_EN` defined: entry (0xFFFFFFFE, step 1, dur 4) → `adder` goes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. A write to entry 1 while entry 0 is playing is used when entry 1 is loaded.
